// File: rtl/opto_encoder_emu.sv
// Purpose : emulates the spindle motor plus slotted code disk; turns the measured motor PWM duty
//           into an opto-switch tooth waveform with spin-up, lock, spin-down and dropped-tooth faults.
// Latency : PWM sync 2 clocks + edge detect 1 clock; tooth period changes land on tooth boundaries.
// Backpressure: none; free-running generator, every output is registered.
//
// Ports:
//   i_clk_50m, i_rst_n   50 MHz clock, asynchronous active-low reset
//   i_enable             0 forces IDLE with the opto output parked high
//   i_motor_pwm          asynchronous motor PWM from the rotor control path
//   i_duty_min           minimum high count per PWM frame that counts as "driven"
//   i_tooth_clks         tooth period at full speed (clamped below at MIN_TOOTH)
//   i_ramp_step          tooth-period change per tooth boundary while ramping
//   i_inject_drop        rising edge requests suppression of the next tooth's edges
//   o_opto_switch        emulated opto-switch level (low first half of a tooth, high second half)
//   o_duty               last measured PWM high count
//   o_state              0 IDLE, 1 SPINUP, 2 LOCKED, 3 SPINDOWN
//   o_locked             high while LOCKED
//   o_rev_pulse          one clock at each emitted tooth-0 rising edge
//   o_tooth_idx          index of the tooth currently being generated

module opto_encoder_emu #(
    parameter int TEETH_PER_REV = 39,
    parameter int PWM_PERIOD    = 1000,
    parameter int START_CLKS    = 400000,
    parameter int STOP_CLKS     = 1000000,
    parameter int MIN_TOOTH     = 4
) (
    input  logic        i_clk_50m,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_motor_pwm,
    input  logic [15:0] i_duty_min,
    input  logic [23:0] i_tooth_clks,
    input  logic [15:0] i_ramp_step,
    input  logic        i_inject_drop,
    output logic        o_opto_switch,
    output logic [15:0] o_duty,
    output logic [1:0]  o_state,
    output logic        o_locked,
    output logic        o_rev_pulse,
    output logic [7:0]  o_tooth_idx
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SPINUP   = 2'd1,
        S_LOCKED   = 2'd2,
        S_SPINDOWN = 2'd3
    } state_t;

    localparam int               TO_LIM       = 2 * PWM_PERIOD;
    localparam int               TO_W         = $clog2(TO_LIM + 1);
    localparam logic [TO_W-1:0]  C_TO_LIM     = TO_W'(TO_LIM);
    localparam logic [TO_W-1:0]  C_TO_ONE     = TO_W'(1);
    localparam logic [15:0]      C_PWM_PERIOD = 16'(PWM_PERIOD);
    localparam logic [23:0]      C_START      = 24'(START_CLKS);
    localparam logic [23:0]      C_STOP       = 24'(STOP_CLKS);
    localparam logic [23:0]      C_MIN        = 24'(MIN_TOOTH);
    localparam logic [7:0]       C_LAST_TOOTH = 8'(TEETH_PER_REV - 1);

    // ------------------------------------------------------------------
    // PWM duty measurement
    // ------------------------------------------------------------------
    logic            r_pwm_s1;
    logic            r_pwm_s2;
    logic            r_pwm_d;
    logic [15:0]     r_high_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic [15:0]     r_duty;
    logic            w_pwm_rise;
    logic            w_driven;

    assign w_pwm_rise = r_pwm_s2 & ~r_pwm_d;

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm_s1   <= 1'b0;
            r_pwm_s2   <= 1'b0;
            r_pwm_d    <= 1'b0;
            r_high_cnt <= 16'd0;
            r_to_cnt   <= '0;
            r_duty     <= 16'd0;
        end else begin
            r_pwm_s1 <= i_motor_pwm;
            r_pwm_s2 <= r_pwm_s1;
            r_pwm_d  <= r_pwm_s2;
            if (w_pwm_rise) begin
                // The rising-edge clock is itself high, so the new frame starts at 1.
                r_duty     <= r_high_cnt;
                r_high_cnt <= 16'd1;
                r_to_cnt   <= '0;
            end else begin
                if (r_pwm_s2 && (r_high_cnt != 16'hFFFF)) begin
                    r_high_cnt <= r_high_cnt + 16'd1;
                end
                if (r_to_cnt != C_TO_LIM) begin
                    r_to_cnt <= r_to_cnt + C_TO_ONE;
                end else begin
                    // No edges for two frames: PWM is stuck at 0% or 100%.
                    // Keep tracking the level so a later high-to-low step is seen.
                    r_duty <= r_pwm_s2 ? C_PWM_PERIOD : 16'd0;
                end
            end
        end
    end

    assign w_driven = (r_duty >= i_duty_min) && i_enable;

    // ------------------------------------------------------------------
    // Tooth-period arithmetic (25-bit so neither direction wraps)
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [23:0] r_period;
    logic [23:0] r_phase;
    logic [7:0]  r_tooth_idx;
    logic        r_drop_act;
    logic        r_drop_pend;
    logic        r_inj_d;
    logic        r_opto;
    logic        r_rev;
    logic        r_locked;

    logic [23:0] w_target;
    logic        w_boundary;
    logic [24:0] w_sub;
    logic [24:0] w_add;
    logic [23:0] w_add_sat;
    logic [23:0] w_ramp;
    logic        w_inj_rise;

    assign w_target   = (i_tooth_clks < C_MIN) ? C_MIN : i_tooth_clks;
    assign w_boundary = (r_phase == (r_period - 24'd1));
    assign w_sub      = {1'b0, r_period} - {9'd0, i_ramp_step};
    assign w_add      = {1'b0, r_period} + {9'd0, i_ramp_step};
    assign w_add_sat  = w_add[24] ? 24'hFFFFFF : w_add[23:0];
    assign w_inj_rise = i_inject_drop & ~r_inj_d;

    // Ramp one step toward the target, never overshooting it.
    always_comb begin
        w_ramp = r_period;
        if (r_period > w_target) begin
            w_ramp = (w_sub[24] || (w_sub[23:0] < w_target)) ? w_target : w_sub[23:0];
        end else if (r_period < w_target) begin
            w_ramp = (w_add > {1'b0, w_target}) ? w_target : w_add[23:0];
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic for the motor model and tooth generator
    // ------------------------------------------------------------------
    state_t      w_state_nxt;
    logic [23:0] w_period_nxt;
    logic [23:0] w_phase_nxt;
    logic [7:0]  w_idx_nxt;
    logic        w_drop_nxt;
    logic        w_pend_nxt;
    logic        w_opto_nxt;
    logic        w_rev_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_period_nxt = r_period;
        w_phase_nxt  = r_phase;
        w_idx_nxt    = r_tooth_idx;
        w_drop_nxt   = r_drop_act;
        w_pend_nxt   = r_drop_pend | w_inj_rise;

        if (!i_enable) begin
            w_state_nxt  = S_IDLE;
            w_period_nxt = C_STOP;
            w_drop_nxt   = 1'b0;
        end else if (r_state == S_IDLE) begin
            // Disk at rest: phase and index frozen, output parked high.
            w_period_nxt = C_STOP;
            w_drop_nxt   = 1'b0;
            if (w_driven) begin
                w_state_nxt  = S_SPINUP;
                w_period_nxt = C_START;
                w_phase_nxt  = 24'd0;
                w_idx_nxt    = 8'd0;
                // The first tooth after start counts as a "next tooth" for a waiting drop.
                w_drop_nxt   = r_drop_pend;
                w_pend_nxt   = w_inj_rise;
            end
        end else begin
            if (w_boundary) begin
                w_phase_nxt = 24'd0;
                w_idx_nxt   = (r_tooth_idx == C_LAST_TOOTH) ? 8'd0 : (r_tooth_idx + 8'd1);
                // A request that arrives on the boundary clock waits for the tooth after.
                w_drop_nxt  = r_drop_pend;
                w_pend_nxt  = w_inj_rise;
            end else begin
                w_phase_nxt = r_phase + 24'd1;
            end

            case (r_state)
                S_SPINUP, S_LOCKED: begin
                    if (!w_driven) begin
                        w_state_nxt = S_SPINDOWN;
                    end else if (w_boundary) begin
                        w_period_nxt = w_ramp;
                        w_state_nxt  = (w_ramp == w_target) ? S_LOCKED : S_SPINUP;
                    end else if ((r_state == S_LOCKED) && (r_period != w_target)) begin
                        // Target moved: report ramping at once; the period follows at the boundary.
                        w_state_nxt = S_SPINUP;
                    end
                end
                default: begin
                    if (w_driven) begin
                        w_state_nxt = S_SPINUP;
                    end else if (w_boundary) begin
                        if (w_add_sat >= C_STOP) begin
                            w_state_nxt  = S_IDLE;
                            w_period_nxt = C_STOP;
                            w_drop_nxt   = 1'b0;
                            w_pend_nxt   = r_drop_pend | w_inj_rise;
                        end else begin
                            w_period_nxt = w_add_sat;
                        end
                    end
                end
            endcase
        end
    end

    // Output is computed from the next phase/period so the registered level
    // always matches the registered phase it describes.
    assign w_opto_nxt = (w_state_nxt == S_IDLE) || w_drop_nxt ||
                        (w_phase_nxt >= (w_period_nxt >> 1));
    // A dropped tooth keeps the line high, so it never produces a 0->1 here.
    assign w_rev_nxt  = (w_state_nxt != S_IDLE) && !r_opto && w_opto_nxt &&
                        (w_idx_nxt == 8'd0);

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_period    <= C_STOP;
            r_phase     <= 24'd0;
            r_tooth_idx <= 8'd0;
            r_drop_act  <= 1'b0;
            r_drop_pend <= 1'b0;
            r_inj_d     <= 1'b0;
            r_opto      <= 1'b1;
            r_rev       <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_period    <= w_period_nxt;
            r_phase     <= w_phase_nxt;
            r_tooth_idx <= w_idx_nxt;
            r_drop_act  <= w_drop_nxt;
            r_drop_pend <= w_pend_nxt;
            r_inj_d     <= i_inject_drop;
            r_opto      <= w_opto_nxt;
            r_rev       <= w_rev_nxt;
            r_locked    <= (w_state_nxt == S_LOCKED);
        end
    end

    assign o_opto_switch = r_opto;
    assign o_duty        = r_duty;
    assign o_state       = r_state;
    assign o_locked      = r_locked;
    assign o_rev_pulse   = r_rev;
    assign o_tooth_idx   = r_tooth_idx;

endmodule

// File: tb/tb_opto_encoder_emu.sv
// Purpose : scoreboard bench for opto_encoder_emu with scaled-down timing parameters.
// Latency : expected tooth periods / revolution shapes are queued when stimulus changes.
// Backpressure: n/a; the monitor pops and compares as falls and rev pulses appear.

module tb_opto_encoder_emu;

    localparam int P_TEETH = 5;
    localparam int P_PWM   = 20;
    localparam int P_START = 400;
    localparam int P_STOP  = 1000;
    localparam int P_MIN   = 4;
    localparam int PWM_HI  = 8;

    logic        i_clk_50m = 1'b0;
    logic        i_rst_n;
    logic        i_enable;
    logic        i_motor_pwm;
    logic [15:0] i_duty_min;
    logic [23:0] i_tooth_clks;
    logic [15:0] i_ramp_step;
    logic        i_inject_drop;
    logic        o_opto_switch;
    logic [15:0] o_duty;
    logic [1:0]  o_state;
    logic        o_locked;
    logic        o_rev_pulse;
    logic [7:0]  o_tooth_idx;

    opto_encoder_emu #(
        .TEETH_PER_REV (P_TEETH),
        .PWM_PERIOD    (P_PWM),
        .START_CLKS    (P_START),
        .STOP_CLKS     (P_STOP),
        .MIN_TOOTH     (P_MIN)
    ) dut (
        .i_clk_50m     (i_clk_50m),
        .i_rst_n       (i_rst_n),
        .i_enable      (i_enable),
        .i_motor_pwm   (i_motor_pwm),
        .i_duty_min    (i_duty_min),
        .i_tooth_clks  (i_tooth_clks),
        .i_ramp_step   (i_ramp_step),
        .i_inject_drop (i_inject_drop),
        .o_opto_switch (o_opto_switch),
        .o_duty        (o_duty),
        .o_state       (o_state),
        .o_locked      (o_locked),
        .o_rev_pulse   (o_rev_pulse),
        .o_tooth_idx   (o_tooth_idx)
    );

    always #10 i_clk_50m = ~i_clk_50m;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard queues: fall-to-fall intervals, and per-revolution rise count / length.
    int fall_q[$];
    int rev_rise_q[$];
    int rev_len_q[$];

    // Monitor state
    int cyc       = 0;
    int fall_cnt  = 0;
    int rise_cnt  = 0;
    int last_fall = 0;
    int rev_c0    = 0;
    int rev_r0    = 0;
    bit fall_have = 1'b0;
    bit rev_have  = 1'b0;
    bit prev_opto = 1'b1;

    int pwm_mode  = 0;   // 0 low, 1 PWM_HI/P_PWM toggling, 2 constant high

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge i_clk_50m);
            #1;
        end
    endtask

    task automatic wait_state(input string tag, input logic [1:0] s, input int limit);
        int k = 0;
        while ((o_state != s) && (k < limit)) begin
            tick(1);
            k++;
        end
        check_val(tag, int'(o_state), int'(s));
    endtask

    task automatic wait_rev(input string tag, input int limit);
        int k = 0;
        do begin
            tick(1);
            k++;
        end while (!o_rev_pulse && (k < limit));
        check_val(tag, int'(o_rev_pulse), 1);
    endtask

    task automatic wait_fall(input string tag, input int limit);
        int f0 = fall_cnt;
        int k  = 0;
        while ((fall_cnt == f0) && (k < limit)) begin
            tick(1);
            k++;
        end
        check_val(tag, fall_cnt - f0, 1);
    endtask

    // Motor PWM source, driven away from the sampling edge.
    initial begin
        int ph = 0;
        i_motor_pwm = 1'b0;
        forever begin
            @(negedge i_clk_50m);
            case (pwm_mode)
                1:       i_motor_pwm = (ph < PWM_HI);
                2:       i_motor_pwm = 1'b1;
                default: i_motor_pwm = 1'b0;
            endcase
            ph = (ph == P_PWM - 1) ? 0 : ph + 1;
        end
    end

    initial begin
        int c_entry;
        int r0;
        int f0;
        int k;

        fork
            forever begin
                @(negedge i_clk_50m);
                cyc++;
                if (o_state == 2'd0) begin
                    fall_have = 1'b0;
                    rev_have  = 1'b0;
                end
                if (prev_opto && !o_opto_switch) begin
                    fall_cnt++;
                    if (fall_have && (fall_q.size() > 0))
                        check_val("tooth_T", cyc - last_fall, fall_q.pop_front());
                    last_fall = cyc;
                    fall_have = 1'b1;
                end
                if (!prev_opto && o_opto_switch)
                    rise_cnt++;
                if (o_rev_pulse) begin
                    if (rev_have && (rev_rise_q.size() > 0)) begin
                        check_val("rev_rises", rise_cnt - rev_r0, rev_rise_q.pop_front());
                        check_val("rev_len", cyc - rev_c0, rev_len_q.pop_front());
                    end
                    rev_have = 1'b1;
                    rev_r0   = rise_cnt;
                    rev_c0   = cyc;
                end
                prev_opto = o_opto_switch;
            end
        join_none

        // ---------------- reset state ----------------
        i_rst_n       = 1'b0;
        i_enable      = 1'b1;
        i_duty_min    = 16'd6;
        i_tooth_clks  = 24'd43;
        i_ramp_step   = 16'd20;
        i_inject_drop = 1'b0;
        tick(3);
        check_val("rst_opto", int'(o_opto_switch), 1);
        check_val("rst_duty", int'(o_duty), 0);
        check_val("rst_state", int'(o_state), 0);
        check_val("rst_locked", int'(o_locked), 0);
        check_val("rst_rev", int'(o_rev_pulse), 0);
        check_val("rst_idx", int'(o_tooth_idx), 0);
        i_rst_n = 1'b1;
        tick(50);
        check_val("idle_no_pwm", int'(o_state), 0);

        // ---------------- spin-up ramp 400 -> 43, step 20 ----------------
        for (int t = P_START; t >= 60; t -= 20) fall_q.push_back(t);
        fall_q.push_back(43);
        fall_q.push_back(43);
        pwm_mode = 1;
        wait_state("spinup", 2'd1, 200);
        c_entry = cyc;
        check_val("duty_meas", int'(o_duty), PWM_HI);
        r0 = rise_cnt;
        k  = 0;
        while ((rise_cnt == r0) && (k < 300)) begin
            tick(1);
            k++;
        end
        check_val("first_rise", cyc - c_entry, P_START / 2);
        wait_state("lock", 2'd2, 6000);
        check_val("locked_flag", int'(o_locked), 1);
        check_val("lock_idx", int'(o_tooth_idx), 18 % P_TEETH);

        // ---------------- steady revolutions ----------------
        wait_rev("rev_a", 400);
        repeat (2) begin
            rev_rise_q.push_back(P_TEETH);
            rev_len_q.push_back(P_TEETH * 43);
        end
        wait_rev("rev_a1", 400);
        wait_rev("rev_a2", 400);
        check_val("ramp_sb_drained", fall_q.size(), 0);

        // ---------------- dropped tooth ----------------
        wait_rev("rev_b", 400);
        i_inject_drop = 1'b1;
        tick(1);
        i_inject_drop = 1'b0;
        fall_q.push_back(2 * 43);
        fall_q.push_back(43);
        rev_rise_q.push_back(P_TEETH - 1);
        rev_len_q.push_back(P_TEETH * 43);
        rev_rise_q.push_back(P_TEETH);
        rev_len_q.push_back(P_TEETH * 43);
        wait_rev("rev_b1", 400);
        wait_rev("rev_b2", 400);
        check_val("drop_sb_drained", fall_q.size() + rev_rise_q.size(), 0);

        // ---------------- PWM stuck high ----------------
        pwm_mode = 2;
        tick(80);
        check_val("duty_const_hi", int'(o_duty), P_PWM);
        check_val("still_locked", int'(o_state), 2);

        // ---------------- target change 43 -> 50 ----------------
        wait_rev("rev_c", 400);
        i_tooth_clks = 24'd50;
        fall_q.push_back(43);
        fall_q.push_back(50);
        fall_q.push_back(50);
        tick(2);
        check_val("retarget_spinup", int'(o_state), 1);
        wait_state("relock", 2'd2, 200);
        wait_rev("rev_d", 400);
        rev_rise_q.push_back(P_TEETH);
        rev_len_q.push_back(P_TEETH * 50);
        wait_rev("rev_e", 400);
        check_val("tgt_sb_drained", fall_q.size() + rev_rise_q.size(), 0);

        // ---------------- spin-down, step 100 ----------------
        i_ramp_step = 16'd100;
        pwm_mode    = 0;
        wait_state("spindown", 2'd3, 200);
        check_val("duty_lo", int'(o_duty), 0);
        wait_fall("sd_fall", 200);
        for (int t = 150; t <= 850; t += 100) fall_q.push_back(t);
        wait_state("stop", 2'd0, 8000);
        check_val("park_hi", int'(o_opto_switch), 1);
        check_val("park_unlocked", int'(o_locked), 0);
        f0 = fall_cnt;
        tick(300);
        check_val("idle_quiet", fall_cnt - f0, 0);
        check_val("sd_sb_drained", fall_q.size(), 0);

        // ---------------- reset during spin-down ----------------
        pwm_mode = 1;
        wait_state("respin", 2'd1, 200);
        wait_state("relock2", 2'd2, 3000);
        pwm_mode = 0;
        wait_state("spindown2", 2'd3, 200);
        tick(100);
        i_rst_n = 1'b0;
        #1;
        check_val("arst_opto", int'(o_opto_switch), 1);
        check_val("arst_state", int'(o_state), 0);
        check_val("arst_duty", int'(o_duty), 0);
        check_val("arst_locked", int'(o_locked), 0);
        check_val("arst_idx", int'(o_tooth_idx), 0);
        tick(5);
        i_rst_n = 1'b1;
        f0 = fall_cnt;
        tick(300);
        check_val("arst_quiet", fall_cnt - f0, 0);
        check_val("arst_stays_idle", int'(o_state), 0);
        pwm_mode = 1;
        wait_state("respin_after_rst", 2'd1, 200);

        // ---------------- enable removed ----------------
        i_enable = 1'b0;
        tick(1);
        check_val("en_off_state", int'(o_state), 0);
        check_val("en_off_park", int'(o_opto_switch), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
